// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column at a time,
// rows synchronized, debounced across whole scans, one pulse per press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAND    = 2'd1;
    localparam logic [1:0] S_PRESSED = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic          acc_vld_q, acc_vld_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          wrap;
    logic          scan_done;
    logic          hit;
    logic [1:0]    hit_row;
    logic          res_vld;
    logic [3:0]    res_code;

    assign wrap      = (div_q == DIV_LAST);
    assign scan_done = wrap && (sel_q == 2'd3);
    assign hit       = ~&sync2_q;

    always_comb begin
        hit_row = 2'd0;
        if (!sync2_q[0])      hit_row = 2'd0;
        else if (!sync2_q[1]) hit_row = 2'd1;
        else if (!sync2_q[2]) hit_row = 2'd2;
        else if (!sync2_q[3]) hit_row = 2'd3;
    end

    // Column 3 is sampled on the same cycle the scan completes,
    // so its hit is merged in combinationally.
    assign res_vld  = acc_vld_q || (wrap && hit);
    assign res_code = acc_vld_q ? acc_code_q : {hit_row, sel_q};

    always_comb begin
        div_d   = wrap ? '0 : div_q + DIV_ONE;
        sel_d   = wrap ? sel_q + 2'd1 : sel_q;
        col_d   = ~(4'b0001 << sel_d);
        sync1_d = row;
        sync2_d = sync1_q;
    end

    always_comb begin
        acc_vld_d  = acc_vld_q;
        acc_code_d = acc_code_q;
        if (scan_done) begin
            acc_vld_d = 1'b0;
        end else if (wrap && hit && !acc_vld_q) begin
            acc_vld_d  = 1'b1;
            acc_code_d = {hit_row, sel_q};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (scan_done) begin
            unique case (state_q)
                S_IDLE: begin
                    if (res_vld) begin
                        if (CNT_MAX == CNT_ONE) begin
                            key_d       = res_code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = S_PRESSED;
                        end else begin
                            cand_d  = res_code;
                            cnt_d   = CNT_ONE;
                            state_d = S_CAND;
                        end
                    end
                end
                S_CAND: begin
                    if (!res_vld) begin
                        state_d = S_IDLE;
                    end else if (res_code == cand_q) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_MAX) begin
                            key_d       = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = S_PRESSED;
                        end
                    end else begin
                        cand_d = res_code;
                        cnt_d  = CNT_ONE;
                    end
                end
                S_PRESSED: begin
                    if (!res_vld) begin
                        if (CNT_MAX == CNT_ONE) begin
                            key_held_d = 1'b0;
                            state_d    = S_IDLE;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = S_RELEASE;
                        end
                    end else if (res_code != key_q) begin
                        cnt_d   = '0;
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!res_vld) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_MAX) begin
                            key_held_d = 1'b0;
                            state_d    = S_IDLE;
                        end
                    end else if (res_code == key_q) begin
                        state_d = S_PRESSED;
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            sel_q       <= 2'd0;
            col_q       <= 4'b1110;
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            acc_vld_q   <= 1'b0;
            acc_code_q  <= 4'h0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            sel_q       <= sel_d;
            col_q       <= col_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            acc_vld_q   <= acc_vld_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col       = col_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
